// File: rtl/shift_register_unit_pkg.sv
// Shared encodings for the accumulator/shift unit: shift modes, directions, FSM states.
package shift_register_unit_pkg;

  localparam int unsigned MODE_WIDTH = 2;

  localparam logic [MODE_WIDTH-1:0] MODE_LOG = 2'b00;
  localparam logic [MODE_WIDTH-1:0] MODE_ARI = 2'b01;
  localparam logic [MODE_WIDTH-1:0] MODE_ROT = 2'b10;
  localparam logic [MODE_WIDTH-1:0] MODE_RTC = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_register_unit_shift_step.sv
// Combinational single-bit shifter: one step of any shift/rotate mode in either direction.
module shift_register_unit_shift_step
  import shift_register_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  carry_i,
  input  logic                  dir_i,
  input  logic [MODE_WIDTH-1:0] mode_i,
  input  logic                  fill_bit_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  carry_o
);

  logic in_bit;

  always_comb begin
    in_bit  = 1'b0;
    word_o  = word_i;
    carry_o = carry_i;
    if (dir_i == DIR_RIGHT) begin
      case (mode_i)
        MODE_LOG: in_bit = fill_bit_i;
        MODE_ARI: in_bit = word_i[DATA_WIDTH-1];
        MODE_ROT: in_bit = word_i[0];
        default:  in_bit = carry_i;
      endcase
      word_o  = {in_bit, word_i[DATA_WIDTH-1:1]};
      carry_o = word_i[0];
    end else begin
      case (mode_i)
        MODE_LOG: in_bit = fill_bit_i;
        MODE_ARI: in_bit = 1'b0;
        MODE_ROT: in_bit = word_i[DATA_WIDTH-1];
        default:  in_bit = carry_i;
      endcase
      word_o  = {word_i[DATA_WIDTH-2:0], in_bit};
      carry_o = word_i[DATA_WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_register_unit.sv
// PicoComputer accumulator: single-cycle clear/load/inc/dec plus multi-cycle shifts with start/busy/done.
module shift_register_unit
  import shift_register_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SHAMT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cl,
  input  logic                   ld,
  input  logic [DATA_WIDTH-1:0]  in,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   shift_start,
  input  logic                   shift_dir,
  input  logic [MODE_WIDTH-1:0]  shift_mode,
  input  logic [SHAMT_WIDTH-1:0] shift_amt,
  input  logic                   fill_bit,
  output logic [DATA_WIDTH-1:0]  out,
  output logic                   carry,
  output logic                   zero,
  output logic                   busy,
  output logic                   done
);

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  out_q;
  logic                   carry_q;
  logic                   busy_q;
  logic                   done_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   dir_q;
  logic [MODE_WIDTH-1:0]  mode_q;

  logic                   step_dir;
  logic [MODE_WIDTH-1:0]  step_mode;
  logic [DATA_WIDTH-1:0]  out_d;
  logic                   carry_d;

  // The first step is taken on the start edge, so it uses the live controls.
  assign step_dir  = (state_q == ST_SHIFT) ? dir_q  : shift_dir;
  assign step_mode = (state_q == ST_SHIFT) ? mode_q : shift_mode;

  shift_register_unit_shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_step (
    .word_i     (out_q),
    .carry_i    (carry_q),
    .dir_i      (step_dir),
    .mode_i     (step_mode),
    .fill_bit_i (fill_bit),
    .word_o     (out_d),
    .carry_o    (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      mode_q  <= MODE_LOG;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_SHIFT: begin
          if (cl) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_q - SHAMT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          if (cl) begin
            out_q   <= '0;
            carry_q <= 1'b0;
          end else if (ld) begin
            out_q   <= in;
            carry_q <= 1'b0;
          end else if (inc) begin
            out_q   <= out_q + DATA_WIDTH'(1);
            carry_q <= &out_q;
          end else if (dec) begin
            out_q   <= out_q - DATA_WIDTH'(1);
            carry_q <= ~|out_q;
          end else if (shift_start) begin
            dir_q  <= shift_dir;
            mode_q <= shift_mode;
            if (shift_amt == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              out_q   <= out_d;
              carry_q <= carry_d;
              cnt_q   <= shift_amt - SHAMT_WIDTH'(1);
              busy_q  <= 1'b1;
              state_q <= ST_SHIFT;
            end
          end
        end
      endcase
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = ~|out_q;

endmodule

// File: tb/tb_shift_register_unit.sv
// Directed bench for shift_register_unit with hand-computed expected values.
module tb_shift_register_unit;

  logic        clk;
  logic        rst_n;
  logic        cl, ld, inc, dec;
  logic [15:0] in;
  logic        shift_start, shift_dir, fill_bit;
  logic [1:0]  shift_mode;
  logic [3:0]  shift_amt;
  logic [15:0] out;
  logic        carry, zero, busy, done;

  int n_vec = 0;
  int n_err = 0;

  shift_register_unit #(.DATA_WIDTH(16), .SHAMT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in), .inc(inc), .dec(dec),
    .shift_start(shift_start), .shift_dir(shift_dir), .shift_mode(shift_mode),
    .shift_amt(shift_amt), .fill_bit(fill_bit),
    .out(out), .carry(carry), .zero(zero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Packs {out, carry, zero, busy, done}; zero is derived from the expected word.
  task automatic expect_st(input string tag, input logic [15:0] eo, input logic ec,
                           input logic eb, input logic ed);
    chk(tag, {12'h0, out, carry, zero, busy, done},
        {12'h0, eo, ec, (eo == 16'h0), eb, ed});
  endtask

  task automatic idle_in();
    cl = 0; ld = 0; inc = 0; dec = 0; shift_start = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic load(input logic [15:0] v);
    ld = 1; in = v;
    tick();
  endtask

  task automatic start(input logic dir, input logic [1:0] mode, input logic [3:0] amt);
    shift_start = 1; shift_dir = dir; shift_mode = mode; shift_amt = amt;
  endtask

  initial begin
    rst_n = 0; in = 16'h0; shift_dir = 0; shift_mode = 2'b00; shift_amt = 4'h0; fill_bit = 0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset", 16'h0000, 0, 0, 0);
    rst_n = 1;

    load(16'h1234);
    expect_st("ld_1234", 16'h1234, 0, 0, 0);

    // cl outranks ld, inc outranks dec
    cl = 1; ld = 1; in = 16'h5555; tick();
    expect_st("cl_over_ld", 16'h0000, 0, 0, 0);
    inc = 1; dec = 1; tick();
    expect_st("inc_over_dec", 16'h0001, 0, 0, 0);

    // arithmetic right by 3
    load(16'h8001);
    start(1'b0, 2'b01, 4'd3); tick();
    expect_st("ari_c1", 16'hC000, 1, 1, 0);
    tick(); expect_st("ari_c2", 16'hE000, 0, 1, 0);
    tick(); expect_st("ari_c3", 16'hF000, 0, 1, 0);
    tick(); expect_st("ari_done", 16'hF000, 0, 0, 1);
    tick(); expect_st("ari_idle", 16'hF000, 0, 0, 0);

    // inc/dec wrap
    load(16'hFFFF);
    inc = 1; tick(); expect_st("inc_wrap", 16'h0000, 1, 0, 0);
    dec = 1; tick(); expect_st("dec_wrap", 16'hFFFF, 1, 0, 0);
    dec = 1; tick(); expect_st("dec_plain", 16'hFFFE, 0, 0, 0);

    // rotate through carry, left by 2
    load(16'h8000);
    start(1'b1, 2'b11, 4'd2); tick();
    expect_st("rtc_c1", 16'h0000, 1, 1, 0);
    tick(); expect_st("rtc_c2", 16'h0001, 0, 1, 0);
    tick(); expect_st("rtc_done", 16'h0001, 0, 0, 1);

    // logical left by 15 with fill 1, ld ignored then cl aborts
    load(16'h0000);
    fill_bit = 1;
    start(1'b1, 2'b00, 4'd15); tick();
    expect_st("log_c1", 16'h0001, 0, 1, 0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      expect_st($sformatf("log_c%0d", k), 16'((32'd1 << k) - 1), 0, 1, 0);
    end
    ld = 1; in = 16'hAAAA; tick();
    expect_st("ld_ignored", 16'h003F, 0, 1, 0);
    cl = 1; tick();
    expect_st("abort", 16'h0000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_st($sformatf("no_done%0d", k), 16'h0000, 0, 0, 0);
    end
    fill_bit = 0;

    // zero count, then back-to-back rotate right from the done cycle
    load(16'h0001);
    start(1'b0, 2'b10, 4'd0); tick();
    expect_st("amt0_done", 16'h0001, 0, 0, 1);
    start(1'b0, 2'b10, 4'd1); tick();
    expect_st("rot_c1", 16'h8000, 1, 1, 0);
    tick(); expect_st("rot_done", 16'h8000, 1, 0, 1);
    tick(); expect_st("rot_idle", 16'h8000, 1, 0, 0);

    // asynchronous reset mid-shift
    load(16'hF0F0);
    start(1'b0, 2'b00, 4'd10); tick();
    expect_st("pre_rst", 16'h7878, 0, 1, 0);
    tick();
    #2 rst_n = 0;
    #1 expect_st("async_rst", 16'h0000, 0, 0, 0);
    tick();
    expect_st("rst_hold", 16'h0000, 0, 0, 0);
    rst_n = 1;
    load(16'h1234);
    expect_st("ld_after_rst", 16'h1234, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_register_unit.md
# shift_register_unit

Parametrised successor of the basic load/inc/dec/shift register. Holds one DATA_WIDTH-bit word and performs clear, load, increment and decrement in a single cycle. Shifts and rotates run over several cycles, by a programmable count, using a start/busy/done handshake. It also keeps a carry flag and a zero flag. It serves as the PicoComputer accumulator/shift unit, sequenced by the control unit.

## Interface
- DATA_WIDTH, 16, word width (≥2)
- SHAMT_WIDTH, 4, width of shift-count input; counts 0..2^SHAMT_WIDTH−1
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cl  in  1  clear word and carry
- ld  in  1  load `in`
- in  in  DATA_WIDTH  load data
- inc  in  1  increment by 1
- dec  in  1  decrement by 1
- shift_start  in  1  start multi-cycle shift
- shift_dir  in  1  0 = right, 1 = left
- shift_mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 rotate-through-carry
- shift_amt  in  SHAMT_WIDTH  number of single-bit steps
- fill_bit  in  1  bit shifted in, logical mode only
- out  out  DATA_WIDTH  current word
- carry  out  1  carry/borrow/last-bit-out flag
- zero  out  1  out == 0
- busy  out  1  shift in progress
- done  out  1  one-cycle pulse, shift complete

## Operation
- Reset state: out=0, carry=0, busy=0, done=0, zero=1, FSM=IDLE.
- FSM has three states: IDLE, SHIFT, DONE.
- Command priority in IDLE or DONE: cl > ld > inc > dec > shift_start. One command executes per cycle.
- cl: out=0, carry=0.
- ld: out=in, carry=0.
- inc: out=out+1 modulo 2^DATA_WIDTH. carry=1 if out was all-ones, else 0.
- dec: out=out−1 modulo 2^DATA_WIDTH. carry=1 (borrow) if out was 0, else 0.
- shift_start: latch shift_dir, shift_mode and shift_amt into internal registers; fill_bit is sampled live during every step.
  - If amt = 0: go to DONE; out and carry are unchanged.
  - If amt > 0: go to SHIFT with remaining count = amt.
- SHIFT state: each cycle performs one single-bit step and decrements the count. After the step that brings the count to 0, go to DONE.
- Single-bit step, right direction:
  - logical: {fill_bit, out[W−1:1]}
  - arithmetic: {out[W−1], out[W−1:1]}
  - rotate: {out[0], out[W−1:1]}
  - rotate-through-carry: {carry, out[W−1:1]}
  - carry ← out[0] in all right modes.
- Single-bit step, left direction:
  - logical: {out[W−2:0], fill_bit}
  - arithmetic: {out[W−2:0], 1'b0}
  - rotate: {out[W−2:0], out[W−1]}
  - rotate-through-carry: {out[W−2:0], carry}
  - carry ← out[W−1] in all left modes.
- DONE state: done=1 for exactly one cycle. Commands are accepted as in IDLE. The next state is SHIFT if a new shift with amt>0 is started, otherwise IDLE.
- While in SHIFT:
  - cl aborts: out=0, carry=0, FSM→IDLE, and done is not pulsed.
  - ld, inc, dec and shift_start are ignored.
- Reset asserted mid-shift forces the full reset state immediately.

## Timing
- out, carry, busy and done are registered. zero is combinational from the out register.
- Single-cycle commands: result on out the cycle after the command is sampled.
- Shift by N>0, started in cycle 0:
  - busy=1 in cycles 1..N.
  - out reflects k steps at cycle k.
  - done=1 in cycle N+1; busy=0 in that cycle.
- Shift by 0: busy stays 0, done=1 in cycle 1.
- busy and done are never high in the same cycle.

## Structure
- Package shift_register_unit_pkg: shift_mode encodings (MODE_LOG, MODE_ARI, MODE_ROT, MODE_RTC), direction constants, FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE).
- One natural sub-module: shift_step, a combinational single-bit shifter. Inputs: word, carry, dir, mode, fill_bit. Outputs: next word, next carry.
- Top level holds the word register, carry register, count register, latched shift controls and the FSM.

## Test plan
- Reset and clear:
  - Assert rst_n=0 mid-operation → out=0x0000, zero=1, carry=0, busy=0, done=0 at once.
  - After releasing reset, ld 0x1234 → out=0x1234 next cycle, zero=0.
- Arithmetic right shift: ld 0x8001, then start arithmetic right, amt=3.
  - busy cycles 1–3; out sequence 0xC000 (carry 1), 0xE000 (carry 0), 0xF000 (carry 0).
  - done in cycle 4.
- Inc/dec wrap:
  - ld 0xFFFF, inc → out=0x0000, carry=1, zero=1.
  - Then dec → out=0xFFFF, carry=1.
  - Then dec → out=0xFFFE, carry=0.
- Rotate through carry, left: ld 0x8000 (carry=0), then start RTC left, amt=2 → out=0x0000/carry=1, then out=0x0001/carry=0, then done.
- Abort and ignore: start logical left, amt=15, fill_bit=1; at busy cycle 5 assert ld 0xAAAA, then cl the next cycle.
  - ld is ignored.
  - The cycle after cl: out=0, carry=0, busy=0.
  - done is never pulsed.
- Zero count and back-to-back: start with amt=0 → done in cycle 1, busy never asserted, out unchanged. In that done cycle start rotate right amt=1 on 0x0001 → out=0x8000, carry=1, done two cycles later.
